// File: rtl/urv_writeback_nbl_pkg.sv
// Shared codes for the uRV non-blocking-load writeback: load width/sign codes, RD source
// selects and the load-queue entry layout.
package urv_writeback_nbl_pkg;

  localparam logic [2:0] LDST_B  = 3'b000;
  localparam logic [2:0] LDST_H  = 3'b001;
  localparam logic [2:0] LDST_L  = 3'b010;
  localparam logic [2:0] LDST_BU = 3'b100;
  localparam logic [2:0] LDST_HU = 3'b101;

  localparam logic [1:0] RD_SOURCE_ALU      = 2'd0;
  localparam logic [1:0] RD_SOURCE_SHIFTER  = 2'd1;
  localparam logic [1:0] RD_SOURCE_MULTIPLY = 2'd2;

  localparam int LQ_FUN_W  = 3;
  localparam int LQ_ADDR_W = 2;
  localparam int LQ_RD_W   = 5;

  typedef struct packed {
    logic [LQ_FUN_W-1:0]  fun;
    logic [LQ_ADDR_W-1:0] addr;
    logic [LQ_RD_W-1:0]   rd;
  } lq_entry_t;

endpackage

// File: rtl/urv_load_align.sv
// Combinational load data aligner: picks byte/half/word by fun and addr[1:0], then sign or
// zero extends. Zero latency, no flow control.
module urv_load_align
  import urv_writeback_nbl_pkg::*;
(
  input  logic [2:0]  fun,
  input  logic [1:0]  addr,
  input  logic [31:0] data,
  output logic [31:0] value
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr)
      2'd0:    byte_sel = data[7:0];
      2'd1:    byte_sel = data[15:8];
      2'd2:    byte_sel = data[23:16];
      default: byte_sel = data[31:24];
    endcase
    half_sel = addr[1] ? data[31:16] : data[15:0];

    case (fun)
      LDST_B:  value = {{24{byte_sel[7]}}, byte_sel};
      LDST_BU: value = {24'h0, byte_sel};
      LDST_H:  value = {{16{half_sel[15]}}, half_sel};
      LDST_HU: value = {16'h0, half_sel};
      LDST_L:  value = data;
      default: value = 32'h0;
    endcase
  end

endmodule

// File: rtl/urv_writeback_nbl.sv
// uRV writeback with an in-order load queue; load responses write the RF with zero latency
// and win the port, non-load writes are held by w_stall_req_o. Option: URV_WB_MISALIGN_TRAP_EN.
module urv_writeback_nbl
  import urv_writeback_nbl_pkg::*;
#(
  parameter int LQ_DEPTH = 4,
  localparam int LQ_AW = $clog2(LQ_DEPTH)
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        w_stall_i,
  output logic        w_stall_req_o,
  input  logic        x_valid_i,
  input  logic        x_load_i,
  input  logic        x_store_i,
  input  logic [2:0]  x_fun_i,
  input  logic [1:0]  x_dm_addr_i,
  input  logic [4:0]  x_rd_i,
  input  logic        x_rd_write_i,
  input  logic [31:0] x_rd_value_i,
  input  logic [31:0] x_shifter_rd_value_i,
  input  logic [31:0] x_multiply_rd_value_i,
  input  logic [1:0]  x_rd_source_i,
  input  logic [31:0] dm_data_l_i,
  input  logic        dm_load_done_i,
  input  logic        dm_store_done_i,
  output logic [4:0]  rf_rd_o,
  output logic [31:0] rf_rd_value_o,
  output logic        rf_rd_write_o,
  output logic [31:0] x_bypass_o,
  output logic [31:0] lq_busy_mask_o,
  output logic        lq_full_o,
  output logic        lq_empty_o,
`ifdef URV_WB_MISALIGN_TRAP_EN
  output logic        x_misaligned_o,
`endif
  output logic        lq_underflow_o
);

  lq_entry_t           lq_mem [LQ_DEPTH];
  logic [LQ_DEPTH-1:0] lq_vld;
  logic [LQ_AW-1:0]    rd_ptr, wr_ptr;
  logic [LQ_AW:0]      lq_count;
  logic                enq, pop, nonload_wr, x_misaligned;
  lq_entry_t           head;
  logic [31:0]         load_value;

  assign lq_full_o  = (lq_count == (LQ_AW+1)'(LQ_DEPTH));
  assign lq_empty_o = (lq_count == '0);
  assign head       = lq_mem[rd_ptr];

`ifdef URV_WB_MISALIGN_TRAP_EN
  always_comb begin
    case (x_fun_i)
      LDST_H, LDST_HU: x_misaligned = x_dm_addr_i[0];
      LDST_L:          x_misaligned = (x_dm_addr_i != 2'b00);
      default:         x_misaligned = 1'b0;
    endcase
  end
  assign x_misaligned_o = x_valid_i & x_load_i & ~w_stall_i & x_misaligned;
`else
  assign x_misaligned = 1'b0;
`endif

  assign enq = x_valid_i & x_load_i & ~w_stall_i & ~lq_full_o & ~x_misaligned;
  assign pop = dm_load_done_i & ~lq_empty_o;
  assign nonload_wr = x_valid_i & x_rd_write_i & ~x_load_i & ~w_stall_i & ~pop;

  assign w_stall_req_o = x_valid_i & ((x_load_i & lq_full_o)
                                      | (x_store_i & ~dm_store_done_i)
                                      | (x_rd_write_i & ~x_load_i & pop));

  urv_load_align u_align (
    .fun   (head.fun),
    .addr  (head.addr),
    .data  (dm_data_l_i),
    .value (load_value)
  );

  always_comb begin
    rf_rd_o       = x_rd_i;
    rf_rd_value_o = x_rd_value_i;
    rf_rd_write_o = nonload_wr;
    if (pop) begin
      rf_rd_o       = head.rd;
      rf_rd_value_o = load_value;
      rf_rd_write_o = (head.rd != 5'd0);
    end else begin
      case (x_rd_source_i)
        RD_SOURCE_SHIFTER:  rf_rd_value_o = x_shifter_rd_value_i;
        RD_SOURCE_MULTIPLY: rf_rd_value_o = x_multiply_rd_value_i;
        default:            rf_rd_value_o = x_rd_value_i;
      endcase
    end
  end

  // x0 entries stay in the queue for ordering but never mark a register busy.
  always_comb begin
    lq_busy_mask_o = 32'h0;
    for (int i = 0; i < LQ_DEPTH; i++)
      if (lq_vld[i] && lq_mem[i].rd != 5'd0)
        lq_busy_mask_o[lq_mem[i].rd] = 1'b1;
  end

  always_ff @(posedge clk_i)
    if (enq)
      lq_mem[wr_ptr] <= '{fun: x_fun_i, addr: x_dm_addr_i, rd: x_rd_i};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      lq_count       <= '0;
      lq_vld         <= '0;
      x_bypass_o     <= 32'h0;
      lq_underflow_o <= 1'b0;
    end else begin
      if (enq) begin
        lq_vld[wr_ptr] <= 1'b1;
        wr_ptr         <= wr_ptr + LQ_AW'(1);
      end
      if (pop) begin
        lq_vld[rd_ptr] <= 1'b0;
        rd_ptr         <= rd_ptr + LQ_AW'(1);
      end
      if (enq && !pop)
        lq_count <= lq_count + (LQ_AW+1)'(1);
      else if (pop && !enq)
        lq_count <= lq_count - (LQ_AW+1)'(1);
      if (rf_rd_write_o)
        x_bypass_o <= rf_rd_value_o;
      if (dm_load_done_i && lq_empty_o)
        lq_underflow_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_urv_writeback_nbl.sv
// Directed bench for urv_writeback_nbl in its default build (LQ_DEPTH=4).
module tb_urv_writeback_nbl;

  logic        clk = 1'b0;
  logic        rst;
  logic        w_stall, w_stall_req;
  logic        x_valid, x_load, x_store, x_rd_write;
  logic [2:0]  x_fun;
  logic [1:0]  x_dm_addr, x_rd_source;
  logic [4:0]  x_rd, rf_rd;
  logic [31:0] x_rd_value, x_shifter_rd_value, x_multiply_rd_value;
  logic [31:0] dm_data_l, rf_rd_value, x_bypass, lq_busy_mask;
  logic        dm_load_done, dm_store_done, rf_rd_write;
  logic        lq_full, lq_empty, lq_underflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  urv_writeback_nbl dut (
    .clk_i                 (clk),
    .rst_i                 (rst),
    .w_stall_i             (w_stall),
    .w_stall_req_o         (w_stall_req),
    .x_valid_i             (x_valid),
    .x_load_i              (x_load),
    .x_store_i             (x_store),
    .x_fun_i               (x_fun),
    .x_dm_addr_i           (x_dm_addr),
    .x_rd_i                (x_rd),
    .x_rd_write_i          (x_rd_write),
    .x_rd_value_i          (x_rd_value),
    .x_shifter_rd_value_i  (x_shifter_rd_value),
    .x_multiply_rd_value_i (x_multiply_rd_value),
    .x_rd_source_i         (x_rd_source),
    .dm_data_l_i           (dm_data_l),
    .dm_load_done_i        (dm_load_done),
    .dm_store_done_i       (dm_store_done),
    .rf_rd_o               (rf_rd),
    .rf_rd_value_o         (rf_rd_value),
    .rf_rd_write_o         (rf_rd_write),
    .x_bypass_o            (x_bypass),
    .lq_busy_mask_o        (lq_busy_mask),
    .lq_full_o             (lq_full),
    .lq_empty_o            (lq_empty),
    .lq_underflow_o        (lq_underflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    w_stall = 0; x_valid = 0; x_load = 0; x_store = 0; x_rd_write = 0;
    x_fun = 3'b010; x_dm_addr = 0; x_rd = 0; x_rd_source = 0;
    x_rd_value = 0; x_shifter_rd_value = 0; x_multiply_rd_value = 0;
    dm_data_l = 0; dm_load_done = 0; dm_store_done = 0;
  endtask

  task automatic issue_load(input logic [2:0] fun, input logic [1:0] addr, input logic [4:0] rd);
    x_valid = 1; x_load = 1; x_rd_write = 0; x_fun = fun; x_dm_addr = addr; x_rd = rd;
  endtask

  initial begin
    logic [4:0] drain_rd [4];
    drain_rd = '{5'd2, 5'd3, 5'd4, 5'd8};
    idle();
    rst = 1;
    tick(); tick();
    rst = 0;
    #1;
    chk("reset_empty", 32'(lq_empty), 1);
    chk("reset_full", 32'(lq_full), 0);
    chk("reset_mask", lq_busy_mask, 0);
    chk("reset_bypass", x_bypass, 0);
    chk("reset_underflow", 32'(lq_underflow), 0);

    // three outstanding LW
    issue_load(3'b010, 2'b00, 5'd5);
    #1 chk("load_no_stall", 32'(w_stall_req), 0);
    chk("load_no_rfwrite", 32'(rf_rd_write), 0);
    tick(); issue_load(3'b010, 2'b00, 5'd6);
    tick(); issue_load(3'b010, 2'b00, 5'd7);
    tick(); idle();
    #1 chk("mask_3_loads", lq_busy_mask, 32'h0000_00E0);
    chk("count_3", 32'(dut.lq_count), 3);
    dm_load_done = 1; dm_data_l = 32'h11;
    #1 chk("resp1_rd", 32'(rf_rd), 5);
    chk("resp1_val", rf_rd_value, 32'h11);
    chk("resp1_we", 32'(rf_rd_write), 1);
    tick(); dm_data_l = 32'h22;
    #1 chk("mask_after_pop1", lq_busy_mask, 32'h0000_00C0);
    chk("resp2_rd", 32'(rf_rd), 6);
    chk("resp2_val", rf_rd_value, 32'h22);
    tick(); dm_data_l = 32'h33;
    #1 chk("resp3_rd", 32'(rf_rd), 7);
    chk("resp3_val", rf_rd_value, 32'h33);
    tick(); idle();
    #1 chk("mask_drained", lq_busy_mask, 0);
    chk("empty_drained", 32'(lq_empty), 1);
    chk("bypass_last_load", x_bypass, 32'h33);

    // fill the queue, then a fifth load must stall
    for (int i = 1; i <= 4; i++) begin
      issue_load(3'b010, 2'b00, 5'(i));
      tick();
    end
    issue_load(3'b010, 2'b00, 5'd8);
    #1 chk("full_flag", 32'(lq_full), 1);
    chk("full_stall", 32'(w_stall_req), 1);
    tick();
    chk("full_no_enq", 32'(dut.lq_count), 4);
    dm_load_done = 1; dm_data_l = 32'hAA;
    #1 chk("full_pop_stall", 32'(w_stall_req), 1);
    chk("full_pop_rd", 32'(rf_rd), 1);
    chk("full_pop_val", rf_rd_value, 32'hAA);
    tick(); dm_load_done = 0;
    #1 chk("freed_count", 32'(dut.lq_count), 3);
    chk("freed_no_stall", 32'(w_stall_req), 0);
    tick(); idle();
    #1 chk("refill_count", 32'(dut.lq_count), 4);
    chk("refill_mask", lq_busy_mask, 32'h0000_011C);
    for (int i = 0; i < 4; i++) begin
      dm_load_done = 1; dm_data_l = 32'(i);
      #1 chk("drain_rd", 32'(rf_rd), 32'(drain_rd[i]));
      tick();
    end
    idle();
    #1 chk("drain_empty", 32'(lq_empty), 1);

    // alignment
    issue_load(3'b000, 2'b11, 5'd10); tick();
    issue_load(3'b100 | 3'b001, 2'b10, 5'd11); tick();
    issue_load(3'b001, 2'b00, 5'd12); tick();
    idle();
    dm_load_done = 1; dm_data_l = 32'h80FF_0000;
    #1 chk("lb_addr3", rf_rd_value, 32'hFFFF_FF80);
    tick();
    #1 chk("lhu_addr2", rf_rd_value, 32'h0000_80FF);
    tick(); dm_data_l = 32'h0000_8001;
    #1 chk("lh_addr0", rf_rd_value, 32'hFFFF_8001);
    tick(); idle();

    // port arbitration: load response beats ADD
    issue_load(3'b010, 2'b00, 5'd9); tick();
    idle();
    x_valid = 1; x_rd_write = 1; x_rd = 5'd3; x_rd_value = 32'h1234;
    dm_load_done = 1; dm_data_l = 32'h55;
    #1 chk("arb_rd_load", 32'(rf_rd), 9);
    chk("arb_val_load", rf_rd_value, 32'h55);
    chk("arb_stall", 32'(w_stall_req), 1);
    tick(); dm_load_done = 0;
    #1 chk("arb_bypass_load", x_bypass, 32'h55);
    chk("arb_rd_add", 32'(rf_rd), 3);
    chk("arb_val_add", rf_rd_value, 32'h1234);
    chk("arb_we_add", 32'(rf_rd_write), 1);
    chk("arb_no_stall", 32'(w_stall_req), 0);
    tick();
    chk("arb_bypass_add", x_bypass, 32'h1234);
    x_rd_source = 2'd1; x_shifter_rd_value = 32'hABCD;
    #1 chk("src_shifter", rf_rd_value, 32'hABCD);
    tick(); x_rd_source = 2'd2; x_multiply_rd_value = 32'h5A5A;
    #1 chk("src_multiply", rf_rd_value, 32'h5A5A);
    w_stall = 1;
    #1 chk("stall_blocks_write", 32'(rf_rd_write), 0);
    tick(); idle();

    // store handshake and stalled load
    x_valid = 1; x_store = 1;
    #1 chk("store_wait_stall", 32'(w_stall_req), 1);
    dm_store_done = 1;
    #1 chk("store_done_no_stall", 32'(w_stall_req), 0);
    idle();
    issue_load(3'b010, 2'b00, 5'd20); w_stall = 1;
    tick(); idle();
    #1 chk("stalled_load_not_enq", 32'(lq_empty), 1);

    // x0 load, underflow, reset mid-queue
    issue_load(3'b010, 2'b00, 5'd0); tick(); idle();
    #1 chk("x0_mask", lq_busy_mask, 0);
    chk("x0_queued", 32'(lq_empty), 0);
    dm_load_done = 1; dm_data_l = 32'hDEAD;
    #1 chk("x0_no_write", 32'(rf_rd_write), 0);
    tick();
    #1 chk("underflow_no_write", 32'(rf_rd_write), 0);
    tick(); dm_load_done = 0;
    #1 chk("underflow_set", 32'(lq_underflow), 1);
    tick();
    chk("underflow_sticky", 32'(lq_underflow), 1);
    issue_load(3'b010, 2'b00, 5'd13); tick();
    issue_load(3'b010, 2'b00, 5'd14); tick(); idle();
    #1 chk("pre_reset_mask", lq_busy_mask, 32'h0000_6000);
    rst = 1; tick(); rst = 0;
    #1 chk("rst_empty", 32'(lq_empty), 1);
    chk("rst_mask", lq_busy_mask, 0);
    chk("rst_underflow", 32'(lq_underflow), 0);
    chk("rst_bypass", x_bypass, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
